// File: rtl/fir4_avg_out_stage_if.sv
// Handshake/bus bundle for the FIR averaging output stage.
//   master : drives in_en, in_sum, out_ready; observes results and status
//   slave  : the stage itself; consumes samples, presents results and status
interface fir4_avg_out_stage_if #(
  parameter int unsigned W   = 16,
  parameter int unsigned OVW = 8
) ();
  logic           in_en;
  logic [W+1:0]   in_sum;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           fill_done;
  logic           ovf;
  logic [OVW-1:0] ovf_cnt;

  modport master (
    output in_en, in_sum, out_ready,
    input  out_valid, out_data, fill_done, ovf, ovf_cnt
  );

  modport slave (
    input  in_en, in_sum, out_ready,
    output out_valid, out_data, fill_done, ovf, ovf_cnt
  );
endinterface

// File: rtl/fir4_avg_out_stage.sv
// Downstream stage of the 4-tap unsigned averaging FIR.
// Takes the (W+2)-bit tap sum on each in_en, divides by 4 with round-half-up,
// saturates to W bits, drops the first DISCARD samples after reset (tap chain
// still holding zeros) and queues results in a DEPTH-entry FIFO behind a
// valid/ready handshake. Results arriving at a full FIFO are dropped and counted.
// Ports:
//   clk    : clock, posedge
//   reset  : synchronous, active-high, clears all state
//   bus    : slave side of fir4_avg_out_stage_if
//            in_en/in_sum in, out_valid/out_ready/out_data handshake,
//            fill_done, ovf (sticky), ovf_cnt (saturating drop count)
module fir4_avg_out_stage #(
  parameter int unsigned W       = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DISCARD = 4,
  parameter int unsigned OVW     = 8
) (
  input logic                  clk,
  input logic                  reset,
  fir4_avg_out_stage_if.slave  bus
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned DCW = (DISCARD > 1) ? $clog2(DISCARD) : 1;

  typedef enum logic {FILL, RUN} state_t;
  localparam state_t START = (DISCARD == 0) ? RUN : FILL;

  state_t         state;
  logic [DCW-1:0] dcnt;
  logic [W-1:0]   mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [AW:0]    count;
  logic [AW:0]    count_next;
  logic           out_valid_r;
  logic [W-1:0]   out_data_r;
  logic           fill_done_r;
  logic           ovf_r;
  logic [OVW-1:0] ovf_cnt_r;

  logic [W+2:0]   sum_ext;
  logic [W+2:0]   avg_ext;
  logic [W-1:0]   avg;
  logic           full;
  logic           do_pop;
  logic           do_push;
  logic           do_drop;
  logic           in_run;

  always_comb begin
    sum_ext = {1'b0, bus.in_sum} + (W+3)'(2);
    avg_ext = sum_ext >> 2;
    // Only avg_ext[W] can be set in practice; any high bit means saturate.
    avg     = (|avg_ext[W+2:W]) ? '1 : avg_ext[W-1:0];

    full    = (count == (AW+1)'(DEPTH));
    do_pop  = out_valid_r && bus.out_ready;
    in_run  = bus.in_en && (state == RUN);
    // A pop in the same cycle frees the slot, so a push at full still lands.
    do_push = in_run && (!full || do_pop);
    do_drop = in_run && full && !do_pop;

    count_next = count;
    if (do_push && !do_pop)      count_next = count + 1'b1;
    else if (do_pop && !do_push) count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= avg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= START;
      dcnt        <= '0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      fill_done_r <= (START == RUN);
      ovf_r       <= 1'b0;
      ovf_cnt_r   <= '0;
    end else begin
      if (state == FILL && bus.in_en) begin
        dcnt <= dcnt + 1'b1;
        if (dcnt == DCW'(DISCARD - 1)) begin
          state       <= RUN;
          fill_done_r <= 1'b1;
        end
      end

      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count       <= count_next;
      out_valid_r <= (count_next != '0);

      // Head register: advance to the next stored entry on pop, or load the
      // incoming result when it becomes the new head; otherwise hold.
      if (do_pop && count > (AW+1)'(1))
        out_data_r <= mem[rptr + 1'b1];
      else if (do_push && count_next == (AW+1)'(1))
        out_data_r <= avg;

      if (do_drop) begin
        ovf_r <= 1'b1;
        if (ovf_cnt_r != '1) ovf_cnt_r <= ovf_cnt_r + 1'b1;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.fill_done = fill_done_r;
  assign bus.ovf       = ovf_r;
  assign bus.ovf_cnt   = ovf_cnt_r;

endmodule

// File: tb/tb_fir4_avg_out_stage.sv
// Self-checking bench for fir4_avg_out_stage (W=16, DEPTH=4, DISCARD=4, OVW=8).
// Expected results are queued when a sample is driven and compared when the
// stage hands the head over to the consumer.
module tb_fir4_avg_out_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  fir4_avg_out_stage_if #(.W(16), .OVW(8)) bus ();

  fir4_avg_out_stage #(
    .W(16),
    .DEPTH(4),
    .DISCARD(4),
    .OVW(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int unsigned ncmp = 0;
  int unsigned nerr = 0;

  // reference model state
  logic [15:0] q[$];
  int unsigned m_disc;
  bit          m_run;
  bit          m_ovf;
  int unsigned m_cnt;

  function automatic logic [15:0] exp_avg(input logic [17:0] s);
    int unsigned t;
    t = (int'(s) + 2) / 4;
    if (t > 65535) t = 65535;
    return t[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    q.delete();
    m_disc = 0;
    m_run  = 1'b0;
    m_ovf  = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.in_en     = 1'b0;
    bus.in_sum    = '0;
    bus.out_ready = 1'b0;
    tick();
    reset = 1'b0;
    model_clear();
  endtask

  // Drive one cycle; a pop is scored against the scoreboard head.
  task automatic drive_cycle(input logic en, input logic [17:0] sum, input logic rdy);
    bus.in_en     = en;
    bus.in_sum    = sum;
    bus.out_ready = rdy;
    if (rdy && q.size() != 0) begin
      ncmp++;
      if (bus.out_data !== q[0])
        $display("FAIL pop_data: got %0d expected %0d", bus.out_data, q[0]);
      if (bus.out_data !== q[0]) nerr++;
      void'(q.pop_front());
    end
    if (en) begin
      if (!m_run) begin
        m_disc++;
        if (m_disc == 4) m_run = 1'b1;
      end else if (q.size() < 4) begin
        q.push_back(exp_avg(sum));
      end else begin
        m_ovf = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    tick();
    bus.in_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    ncmp++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'd0 || bus.fill_done !== 1'b0 ||
        bus.ovf !== 1'b0 || bus.ovf_cnt !== 8'd0) begin
      nerr++;
      $display("FAIL reset_state: valid=%0b data=%0d fill=%0b ovf=%0b cnt=%0d expected 0/0/0/0/0",
               bus.out_valid, bus.out_data, bus.fill_done, bus.ovf, bus.ovf_cnt);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 18'd1000, 1'b1);
      ncmp++;
      if (bus.out_valid !== 1'b0 || bus.fill_done !== (i == 3)) begin
        nerr++;
        $display("FAIL fill_step%0d: valid=%0b fill=%0b expected 0/%0b",
                 i, bus.out_valid, bus.fill_done, i == 3);
      end
    end
  endtask

  task automatic test_rounding();
    logic [17:0] sums [4];
    logic [15:0] exps [4];
    sums = '{18'd10, 18'd11, 18'd262140, 18'd262143};
    exps = '{16'd3, 16'd3, 16'd65535, 16'd65535};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, sums[i], 1'b1);
      ncmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exps[i]) begin
        nerr++;
        $display("FAIL round_%0d: valid=%0b data=%0d expected 1/%0d",
                 sums[i], bus.out_valid, bus.out_data, exps[i]);
      end
    end
    drive_cycle(1'b0, '0, 1'b1);
    ncmp++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'd65535) begin
      nerr++;
      $display("FAIL empty_hold: valid=%0b data=%0d expected 0/65535",
               bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 18'(400 + 40 * i), 1'b0);
    ncmp++;
    if (bus.ovf !== 1'b1 || bus.ovf_cnt !== 8'd2 || bus.out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL overflow: ovf=%0b cnt=%0d valid=%0b expected 1/2/1",
               bus.ovf, bus.ovf_cnt, bus.out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, '0, 1'b1);
      ncmp++;
      if (bus.out_valid !== (i != 3)) begin
        nerr++;
        $display("FAIL drain_valid%0d: got %0b expected %0b", i, bus.out_valid, i != 3);
      end
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 18'(2000 + 8 * i), 1'b0);
    drive_cycle(1'b1, 18'd1000, 1'b1);
    ncmp++;
    if (bus.ovf_cnt !== 8'd2 || bus.out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL full_push_pop: cnt=%0d valid=%0b expected 2/1", bus.ovf_cnt, bus.out_valid);
    end
    // Still full afterwards: one more push without pop must be dropped.
    drive_cycle(1'b1, 18'd1004, 1'b0);
    ncmp++;
    if (bus.ovf_cnt !== 8'd3) begin
      nerr++;
      $display("FAIL full_after_pp: cnt=%0d expected 3", bus.ovf_cnt);
    end
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, '0, 1'b1);
    ncmp++;
    if (bus.out_valid !== 1'b0 || q.size() != 0) begin
      nerr++;
      $display("FAIL full_drain: valid=%0b left=%0d expected 0/0", bus.out_valid, q.size());
    end
  endtask

  task automatic test_reset_flush();
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 18'(3000 + 4 * i), 1'b0);
    drive_cycle(1'b0, '0, 1'b1);
    ncmp++;
    if (bus.ovf_cnt !== 8'd5 || bus.out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL pre_flush: cnt=%0d valid=%0b expected 5/1", bus.ovf_cnt, bus.out_valid);
    end
    do_reset();
    ncmp++;
    if (bus.out_valid !== 1'b0 || bus.ovf !== 1'b0 || bus.ovf_cnt !== 8'd0 ||
        bus.fill_done !== 1'b0) begin
      nerr++;
      $display("FAIL flush: valid=%0b ovf=%0b cnt=%0d fill=%0b expected 0/0/0/0",
               bus.out_valid, bus.ovf, bus.ovf_cnt, bus.fill_done);
    end
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 18'd5000, 1'b1);
    ncmp++;
    if (bus.out_valid !== 1'b0 || bus.fill_done !== 1'b1) begin
      nerr++;
      $display("FAIL refill: valid=%0b fill=%0b expected 0/1", bus.out_valid, bus.fill_done);
    end
    drive_cycle(1'b1, 18'd2001, 1'b1);
    ncmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd500) begin
      nerr++;
      $display("FAIL post_flush: valid=%0b data=%0d expected 1/500", bus.out_valid, bus.out_data);
    end
    drive_cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 304; i++) drive_cycle(1'b1, 18'(i * 7), 1'b0);
    ncmp++;
    if (bus.ovf_cnt !== 8'd255 || bus.ovf !== 1'b1 || m_cnt != 255) begin
      nerr++;
      $display("FAIL ovf_saturate: cnt=%0d ovf=%0b expected 255/1", bus.ovf_cnt, bus.ovf);
    end
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, '0, 1'b1);
    ncmp++;
    if (bus.out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL sat_drain: valid=%0b expected 0", bus.out_valid);
    end
  endtask

  initial begin
    bus.in_en     = 1'b0;
    bus.in_sum    = '0;
    bus.out_ready = 1'b0;
    model_clear();
    tick();
    test_reset();
    test_fill();
    test_rounding();
    test_overflow();
    test_full_push_pop();
    test_reset_flush();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
